// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-cache memory arbiter: op and state encodings, bus widths.
// The optional busy timeout is enabled with the ARB_TIMEOUT_EN macro.
package mem_arbiter_pkg;

    localparam int unsigned IOSTATEWIDTH = 2;
    localparam int unsigned ADDRWIDTH    = 8;
    localparam int unsigned WORDWIDTH    = 16;

    localparam logic [IOSTATEWIDTH-1:0] IDEL   = 2'b00;
    localparam logic [IOSTATEWIDTH-1:0] RD     = 2'b01;
    localparam logic [IOSTATEWIDTH-1:0] WT     = 2'b10;
    localparam logic [IOSTATEWIDTH-1:0] ILLGL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } arb_state_e;

    function automatic logic is_op(input logic [IOSTATEWIDTH-1:0] rw);
        return (rw == RD) || (rw == WT);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin pick: on a tie the requester that was not served last wins.
// grant 0 selects A, 1 selects B; valid is high when anyone is eligible.
module arb_rr_pick (
    input  logic eligA,
    input  logic eligB,
    input  logic last,
    output logic grant,
    output logic valid
);

    always_comb begin
        valid = eligA | eligB;
        grant = (eligA && eligB) ? ~last : eligB;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two cache ports onto one memory port with an IDLE/BUSY/DONE handshake.
// Define ARB_TIMEOUT_EN to abort a BUSY transaction after TIMEOUT cycles without an ack.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNTW    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IOSTATEWIDTH-1:0] rwFromCacheA,
    input  logic [ADDRWIDTH-1:0]    addrFromCacheA,
    input  logic [WORDWIDTH-1:0]    dataFromCacheA,
    output logic [WORDWIDTH-1:0]    dataToCacheA,
    output logic                    doneToCacheA,
    input  logic [IOSTATEWIDTH-1:0] rwFromCacheB,
    input  logic [ADDRWIDTH-1:0]    addrFromCacheB,
    input  logic [WORDWIDTH-1:0]    dataFromCacheB,
    output logic [WORDWIDTH-1:0]    dataToCacheB,
    output logic                    doneToCacheB,
    output logic [IOSTATEWIDTH-1:0] rwToMem,
    output logic [ADDRWIDTH-1:0]    addrToMem,
    output logic [WORDWIDTH-1:0]    dataToMem,
    input  logic [WORDWIDTH-1:0]    dataFromMem,
    input  logic                    doneFromMem,
    output logic                    owner,
    output logic [1:0]              errFlags
);

    arb_state_e              r_state, w_state_next;
    logic [IOSTATEWIDTH-1:0] r_rw;
    logic [ADDRWIDTH-1:0]    r_addr;
    logic [WORDWIDTH-1:0]    r_data;
    logic [WORDWIDTH-1:0]    r_rd_a, r_rd_b;
    logic                    r_owner;
    logic                    r_err_ill;
    logic                    w_err_to;
    logic                    w_elig_a, w_elig_b, w_grant, w_valid;
    logic                    w_start, w_mem_done, w_timeout, w_finish;

    assign w_elig_a = is_op(rwFromCacheA);
    assign w_elig_b = is_op(rwFromCacheB);

    arb_rr_pick u_pick (
        .eligA (w_elig_a),
        .eligB (w_elig_b),
        .last  (r_owner),
        .grant (w_grant),
        .valid (w_valid)
    );

    assign w_start    = (r_state == IDLE) && w_valid;
    assign w_mem_done = (r_state == BUSY) && doneFromMem;
    assign w_finish   = w_mem_done || w_timeout;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start)  w_state_next = BUSY;
            BUSY:    if (w_finish) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs: the done pulse is simply the single DONE cycle steered to the grantee
    always_comb begin
        doneToCacheA = (r_state == DONE) && !r_owner;
        doneToCacheB = (r_state == DONE) && r_owner;
        rwToMem      = r_rw;
        addrToMem    = r_addr;
        dataToMem    = r_data;
        dataToCacheA = r_rd_a;
        dataToCacheB = r_rd_b;
        owner        = r_owner;
        errFlags     = {w_err_to, r_err_ill};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rw      <= IDEL;
            r_addr    <= '0;
            r_data    <= '0;
            r_rd_a    <= '0;
            r_rd_b    <= '0;
            r_owner   <= 1'b1;
            r_err_ill <= 1'b0;
        end else begin
            if ((r_state == IDLE) && ((rwFromCacheA == ILLGL) || (rwFromCacheB == ILLGL))) begin
                r_err_ill <= 1'b1;
            end
            if (w_start) begin
                r_owner <= w_grant;
                r_rw    <= w_grant ? rwFromCacheB   : rwFromCacheA;
                r_addr  <= w_grant ? addrFromCacheB : addrFromCacheA;
                r_data  <= w_grant ? dataFromCacheB : dataFromCacheA;
            end
            if (w_finish) begin
                r_rw <= IDEL;
            end
            if (w_mem_done && (r_rw == RD)) begin
                if (r_owner) r_rd_b <= dataFromMem;
                else         r_rd_a <= dataFromMem;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

    logic [CNTW-1:0] r_cnt;
    logic            r_err_to;

    // Fires on the TIMEOUT-th BUSY cycle; a same-edge memory ack wins
    assign w_timeout = (r_state == BUSY) && !doneFromMem && (r_cnt == CNT_LAST);
    assign w_err_to  = r_err_to;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_err_to <= 1'b0;
        end else begin
            if (w_start)                r_cnt <= '0;
            else if (r_state == BUSY)   r_cnt <= r_cnt + 1'b1;
            if (w_timeout)              r_err_to <= 1'b1;
        end
    end
`else
    logic [31:0] w_unused_cfg;

    assign w_unused_cfg = TIMEOUT + CNTW;
    assign w_timeout    = 1'b0;
    assign w_err_to     = 1'b0;
`endif

endmodule
